// File: rtl/chip_test_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : chip_test_scheduler
//  Description : Owns the shared DUT socket. Latches a tester selection on a
//                Start edge, launches that tester, muxes its pin drive onto
//                the socket, waits for Done or timeout, and holds a pass/fail
//                verdict until the user acknowledges it.
//  Revision    : 1.0 - initial release
// ============================================================================
module chip_test_scheduler #(
  parameter int N_TESTERS = 4,
  parameter int SEL_W     = 2,
  parameter int PIN_W     = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Start,
  input  logic [SEL_W-1:0]           Sel,
  input  logic                       Ack,
  output logic [N_TESTERS-1:0]       tst_run,
  input  logic [N_TESTERS-1:0]       tst_done,
  input  logic [N_TESTERS-1:0]       tst_rslt,
  output logic [N_TESTERS-1:0]       tst_disp,
  input  logic [N_TESTERS*PIN_W-1:0] tst_drive,
  output logic [PIN_W-1:0]           dut_drive,
  output logic [SEL_W-1:0]           Active_sel,
  output logic                       Busy,
  output logic                       Done,
  output logic                       Pass,
  output logic                       Fail,
  output logic                       Timeout,
  output logic                       BadSel
);

  // Timer only has to reach TIMEOUT-1; one extra code leaves room to saturate.
  localparam int                 TMR_W      = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0]   c_tmr_last = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0]   c_tmr_max  = '1;
  localparam logic [SEL_W:0]     c_n_testers = (SEL_W + 1)'(N_TESTERS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_RUN     = 3'd2,
    S_SAMPLE  = 3'd3,
    S_RESULT  = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_start_q;
  logic                  r_ack_q;
  logic                  r_armed;
  logic [TMR_W-1:0]      r_timer;
  logic [TMR_W-1:0]      w_timer_nxt;
  logic [SEL_W-1:0]      r_sel;
  logic [SEL_W-1:0]      w_sel_nxt;
  logic [N_TESTERS-1:0]  r_run;
  logic [N_TESTERS-1:0]  r_disp;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_fail;
  logic                  r_timeout;
  logic                  r_badsel;
  logic                  w_pass_nxt;
  logic                  w_fail_nxt;
  logic                  w_timeout_nxt;
  logic                  w_badsel_nxt;
  logic                  w_start_rise;
  logic                  w_ack_rise;
  logic                  w_sel_ok;
  logic                  w_cur_done;
  logic                  w_cur_rslt;
  logic [PIN_W-1:0]      w_cur_drive;

  function automatic logic [N_TESTERS-1:0] f_onehot(input logic [SEL_W-1:0] s);
    logic [N_TESTERS-1:0] v;
    v = '0;
    for (int i = 0; i < N_TESTERS; i++) begin
      if (s == SEL_W'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Edges are only honoured once a clock has passed since reset, so levels
  // already high at reset release do not count as edges.
  assign w_start_rise = Start & ~r_start_q & r_armed;
  assign w_ack_rise   = Ack   & ~r_ack_q   & r_armed;
  assign w_sel_ok     = ({1'b0, Sel} < c_n_testers);

  // Edge-detect history for the user Start/Ack levels.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_start_q <= 1'b0;
      r_ack_q   <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_start_q <= Start;
      r_ack_q   <= Ack;
      r_armed   <= 1'b1;
    end
  end

  // Pick out the active tester's done/result/drive (select held in r_sel).
  always_comb begin
    w_cur_done  = 1'b0;
    w_cur_rslt  = 1'b0;
    w_cur_drive = '0;
    for (int i = 0; i < N_TESTERS; i++) begin
      if (r_sel == SEL_W'(i)) begin
        w_cur_done  = tst_done[i];
        w_cur_rslt  = tst_rslt[i];
        w_cur_drive = tst_drive[i*PIN_W +: PIN_W];
      end
    end
  end

  // Next-state, timer and verdict logic.
  always_comb begin
    w_next        = r_state;
    w_sel_nxt     = r_sel;
    w_timer_nxt   = r_timer;
    w_pass_nxt    = r_pass;
    w_fail_nxt    = r_fail;
    w_timeout_nxt = r_timeout;
    w_badsel_nxt  = r_badsel;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          if (w_sel_ok) begin
            w_next        = S_LAUNCH;
            w_sel_nxt     = Sel;
            w_pass_nxt    = 1'b0;
            w_fail_nxt    = 1'b0;
            w_timeout_nxt = 1'b0;
            w_badsel_nxt  = 1'b0;
          end else begin
            w_badsel_nxt  = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        w_timer_nxt = '0;
        w_next      = S_RUN;
      end
      S_RUN: begin
        if (r_timer != c_tmr_max) w_timer_nxt = r_timer + 1'b1;
        // Done takes priority over an expiring timer in the same cycle.
        if (w_cur_done) begin
          w_next = S_SAMPLE;
        end else if (r_timer == c_tmr_last) begin
          w_fail_nxt    = 1'b1;
          w_timeout_nxt = 1'b1;
          w_next        = S_RELEASE;
        end
      end
      S_SAMPLE: begin
        w_pass_nxt = w_cur_rslt;
        w_fail_nxt = ~w_cur_rslt;
        w_next     = S_RESULT;
      end
      S_RESULT: begin
        if (w_ack_rise) w_next = S_RELEASE;
      end
      S_RELEASE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register; outputs are registered from the next state so they line
  // up with the state they describe.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_sel     <= '0;
      r_run     <= '0;
      r_disp    <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
      r_badsel  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_timer   <= w_timer_nxt;
      r_sel     <= w_sel_nxt;
      r_run     <= (w_next == S_LAUNCH)  ? f_onehot(w_sel_nxt) : '0;
      r_disp    <= (w_next == S_RELEASE) ? f_onehot(w_sel_nxt) : '0;
      r_busy    <= (w_next == S_LAUNCH) || (w_next == S_RUN) || (w_next == S_SAMPLE);
      r_done    <= (w_next == S_RESULT);
      r_pass    <= w_pass_nxt;
      r_fail    <= w_fail_nxt;
      r_timeout <= w_timeout_nxt;
      r_badsel  <= w_badsel_nxt;
    end
  end

  // The socket is driven only while a test is actually in flight.
  assign dut_drive  = r_busy ? w_cur_drive : '0;
  assign tst_run    = r_run;
  assign tst_disp   = r_disp;
  assign Active_sel = r_sel;
  assign Busy       = r_busy;
  assign Done       = r_done;
  assign Pass       = r_pass;
  assign Fail       = r_fail;
  assign Timeout    = r_timeout;
  assign BadSel     = r_badsel;

endmodule
`default_nettype wire

// File: tb/tb_chip_test_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_chip_test_scheduler
//  Description : Self-checking bench for chip_test_scheduler: reset cases,
//                a table of directed transactions and randomized transactions
//                checked against a transaction-level expectation model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_chip_test_scheduler;

  localparam int N  = 3;
  localparam int SW = 2;
  localparam int PW = 16;
  localparam int TO = 100;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            Start = 1'b0;
  logic [SW-1:0]   Sel = '0;
  logic            Ack = 1'b0;
  logic [N-1:0]    tst_done = '0;
  logic [N-1:0]    tst_rslt = '0;
  logic [N*PW-1:0] tst_drive = '0;
  logic [N-1:0]    tst_run;
  logic [N-1:0]    tst_disp;
  logic [PW-1:0]   dut_drive;
  logic [SW-1:0]   Active_sel;
  logic            Busy, Done, Pass, Fail, Timeout, BadSel;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int sel;
    int delay;     // RUN cycle (1-based) in which the tester raises Done
    int rslt;
    int ack_gap;   // RESULT cycles before Ack rises
    int exp_busy;
    int exp_pass;
    int exp_tmo;
    int exp_bad;
  } vec_t;

  chip_test_scheduler #(
    .N_TESTERS (N),
    .SEL_W     (SW),
    .PIN_W     (PW),
    .TIMEOUT   (TO)
  ) u_dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Sel        (Sel),
    .Ack        (Ack),
    .tst_run    (tst_run),
    .tst_done   (tst_done),
    .tst_rslt   (tst_rslt),
    .tst_disp   (tst_disp),
    .tst_drive  (tst_drive),
    .dut_drive  (dut_drive),
    .Active_sel (Active_sel),
    .Busy       (Busy),
    .Done       (Done),
    .Pass       (Pass),
    .Fail       (Fail),
    .Timeout    (Timeout),
    .BadSel     (BadSel)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int s);
    logic [N-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Transaction-level expectation: busy spans launch + run cycles + sample
  // when the tester answers in time, otherwise launch + TO run cycles.
  function automatic vec_t model(input int sel, input int delay, input int rslt, input int gap);
    vec_t v;
    v.sel = sel; v.delay = delay; v.rslt = rslt; v.ack_gap = gap;
    v.exp_bad = (sel >= N) ? 1 : 0;
    if (sel >= N) begin
      v.exp_busy = 0; v.exp_pass = 0; v.exp_tmo = 0;
    end else if (delay <= TO) begin
      v.exp_busy = delay + 2; v.exp_pass = rslt; v.exp_tmo = 0;
    end else begin
      v.exp_busy = TO + 1; v.exp_pass = 0; v.exp_tmo = 1;
    end
    return v;
  endfunction

  task automatic do_txn(input vec_t v, input bit noise);
    int b;
    int k;
    logic [2:0] exp3;
    @(negedge Clk);
    Start = 1'b0; Ack = 1'b0; Sel = SW'(v.sel); tst_done = '0;
    @(negedge Clk);
    Start = 1'b1;
    @(negedge Clk);
    if (v.exp_bad != 0) begin
      chk("badsel_set", BadSel, 1);
      chk("badsel_no_run", tst_run, 0);
      chk("badsel_not_busy", Busy, 0);
      repeat (2) @(negedge Clk);
      chk("badsel_stays_idle", {Busy, Done, tst_run}, 0);
      Start = 1'b0;
      return;
    end
    chk("launch_run", tst_run, oh(v.sel));
    chk("launch_flags_clear", {Pass, Fail, Timeout, BadSel}, 0);
    chk("launch_sel", Active_sel, v.sel);
    b = 0;
    while (Busy && b < TO + 20) begin
      b++;
      k = b - 1;
      chk("busy_active_sel", Active_sel, v.sel);
      chk("busy_drive_mux", dut_drive, tst_drive[v.sel*PW +: PW]);
      if (b > 1) chk("run_single_pulse", tst_run, 0);
      tst_drive = (N*PW)'({$urandom(), $urandom()});
      tst_rslt  = noise ? N'($urandom()) : '0;
      tst_done  = '0;
      if (k >= v.delay) begin
        tst_done[v.sel] = 1'b1;
        tst_rslt[v.sel] = v.rslt[0];
      end
      if (noise) begin
        tst_done = tst_done | (N'($urandom()) & ~oh(v.sel));
        Start = $urandom_range(0, 1) == 1;
        Sel   = SW'($urandom());
        Ack   = $urandom_range(0, 1) == 1;
      end
      @(negedge Clk);
    end
    chk("busy_length", b, v.exp_busy);
    Start = 1'b0; Ack = 1'b0; tst_done = '0;
    chk("idle_drive_zero", dut_drive, 0);
    if (v.exp_tmo == 0) begin
      exp3 = {v.exp_pass[0], ~v.exp_pass[0], 1'b0};
      chk("result_done", Done, 1);
      chk("result_verdict", {Pass, Fail, Timeout}, exp3);
      chk("result_no_disp", tst_disp, 0);
      for (int i = 0; i < v.ack_gap; i++) begin
        @(negedge Clk);
        chk("result_hold", {Done, tst_disp}, {1'b1, {N{1'b0}}});
      end
      Ack = 1'b1;
      @(negedge Clk);
      chk("release_disp", tst_disp, oh(v.sel));
      chk("release_done_low", Done, 0);
    end else begin
      exp3 = 3'b011;
      chk("timeout_no_done", Done, 0);
      chk("timeout_verdict", {Pass, Fail, Timeout}, exp3);
      chk("timeout_disp", tst_disp, oh(v.sel));
    end
    @(negedge Clk);
    chk("disp_one_cycle", tst_disp, 0);
    chk("idle_retained", {Busy, Done, Pass, Fail, Timeout}, {2'b00, exp3});
    Ack = 1'b0;
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    tbl[0] = '{1,  40, 1, 3,  42, 1, 0, 0};
    tbl[1] = '{1,  40, 0, 1,  42, 0, 0, 0};
    tbl[2] = '{3,   0, 0, 0,   0, 0, 0, 1};
    tbl[3] = '{0,   1, 1, 2,   3, 1, 0, 0};
    tbl[4] = '{2, 100, 1, 1, 102, 1, 0, 0};
    tbl[5] = '{2, 101, 1, 1, 101, 0, 1, 0};
    tbl[6] = '{0, 99999, 0, 0, 101, 0, 1, 0};
    tbl[7] = '{2,  99, 0, 4, 101, 0, 0, 0};

    // Power-on reset, with Start and Ack already high at release.
    Start = 1'b1; Ack = 1'b1;
    repeat (3) @(negedge Clk);
    chk("reset_outputs", {tst_run, tst_disp, dut_drive, Active_sel, Busy, Done, Pass, Fail, Timeout, BadSel}, 0);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("no_edge_after_reset", {Busy, tst_run, BadSel, Done, tst_disp}, 0);
    Start = 1'b0; Ack = 1'b0;

    for (int i = 0; i < 8; i++) do_txn(tbl[i], 1'b0);

    // Asynchronous reset in the middle of a run on tester 1.
    @(negedge Clk);
    Sel = 2'd1; Start = 1'b0;
    @(negedge Clk);
    Start = 1'b1;
    repeat (10) @(negedge Clk);
    tst_drive = (N*PW)'({$urandom(), $urandom()});
    chk("midrun_busy", {Busy, Active_sel}, {1'b1, 2'd1});
    #2 Reset = 1'b0;
    #1;
    chk("async_reset_outputs", {tst_run, tst_disp, dut_drive, Active_sel, Busy, Done, Pass, Fail, Timeout, BadSel}, 0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("post_reset_quiet", {tst_disp, tst_run, Busy, dut_drive}, 0);
    end
    Start = 1'b0;

    for (int i = 0; i < 25; i++) begin
      int d;
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(95, 110) : $urandom_range(1, 60);
      rv = model($urandom_range(0, 3), d, $urandom_range(0, 1), $urandom_range(1, 4));
      do_txn(rv, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
